// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the multi-core memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_rr_arbiter_pick.sv
// rr_pick: combinational round-robin picker, first request above last_grant wins
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner,
    output logic         any_req
);
    logic         found;
    logic [W-1:0] idx;
    always_comb begin
        winner = last_grant;
        found = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(last_grant) + i) % N);
            if (!found && req[idx]) begin
                winner = idx;
                found = 1'b1;
            end
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one memory/IO port among N picorv32 cores
import mem_arb_pkg::*;
module mem_rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CORES-1:0]         core_valid,
    input  logic [32*N_CORES-1:0]      core_addr,
    input  logic [32*N_CORES-1:0]      core_wdata,
    input  logic [4*N_CORES-1:0]       core_wstrb,
    output logic [N_CORES-1:0]         core_ready,
    output logic [32*N_CORES-1:0]      core_rdata,
    output logic                       m_valid,
    output logic [31:0]                m_addr,
    output logic [31:0]                m_wdata,
    output logic [3:0]                 m_wstrb,
    input  logic                       m_ready,
    input  logic [31:0]                m_rdata,
    output logic [$clog2(N_CORES)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int W = gid_width(N_CORES);
    localparam int TW = $clog2(TIMEOUT);
    arb_state_t    state;
    logic [W-1:0]  last_grant;
    logic [W-1:0]  winner;
    logic          any_req;
    logic [TW-1:0] tcnt;
    logic          expired;
    logic          done;

    rr_pick #(.N(N_CORES), .W(W)) u_pick (
        .req       (core_valid),
        .last_grant(last_grant),
        .winner    (winner),
        .any_req   (any_req)
    );

    // m_ready on the final ISSUE cycle takes priority over the abort
    assign expired = tcnt == TW'(TIMEOUT - 1);
    assign done = m_ready || expired;
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            m_valid <= 1'b0;
            m_addr <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
            core_ready <= '0;
            core_rdata <= '0;
            grant_id <= '0;
            last_grant <= W'(N_CORES - 1);
            tcnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            core_ready <= '0;
            case (state)
                IDLE: if (any_req) begin
                    state <= ISSUE;
                    m_valid <= 1'b1;
                    m_addr <= core_addr[{winner, 5'd0} +: 32];
                    m_wdata <= core_wdata[{winner, 5'd0} +: 32];
                    m_wstrb <= core_wstrb[{winner, 2'd0} +: 4];
                    grant_id <= winner;
                    tcnt <= '0;
                end
                ISSUE: if (done) begin
                    state <= RESP;
                    m_valid <= 1'b0;
                    core_ready[grant_id] <= 1'b1;
                    core_rdata[{grant_id, 5'd0} +: 32] <= m_ready ? m_rdata : TIMEOUT_RDATA;
                    timeout_err <= timeout_err | ~m_ready;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    last_grant <= grant_id;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed and random checks against a transaction-level model
module tb_mem_rr_arbiter;
    localparam int NC = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    core_valid = '0;
    logic [127:0]  core_addr = '0;
    logic [127:0]  core_wdata = '0;
    logic [15:0]   core_wstrb = '0;
    logic [3:0]    core_ready;
    logic [127:0]  core_rdata;
    logic          m_valid;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_ready = 1'b0;
    logic [31:0]   m_rdata = '0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gcyc = 0;
    int gap = 0;

    logic [31:0] addr [NC];
    logic [31:0] wd [NC];
    logic [3:0]  ws [NC];
    logic [31:0] mrd [NC];
    int          last_g;
    logic        terr;

    mem_rr_arbiter #(.N_CORES(NC), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_ready(core_ready), .core_rdata(core_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] req);
        for (int i = 1; i <= NC; i++)
            if (req[(last_g + i) % NC]) return (last_g + i) % NC;
        return -1;
    endfunction

    function automatic logic [127:0] model_rdata();
        return {mrd[3], mrd[2], mrd[1], mrd[0]};
    endfunction

    task automatic drive_cores();
        core_addr = {addr[3], addr[2], addr[1], addr[0]};
        core_wdata = {wd[3], wd[2], wd[1], wd[0]};
        core_wstrb = {ws[3], ws[2], ws[1], ws[0]};
    endtask

    task automatic rnd_cores();
        for (int k = 0; k < NC; k++) begin
            addr[k] = $urandom;
            wd[k] = $urandom;
            ws[k] = 4'($urandom);
        end
        drive_cores();
    endtask

    task automatic model_reset();
        last_g = NC - 1;
        terr = 1'b0;
        for (int k = 0; k < NC; k++) mrd[k] = '0;
    endtask

    // one complete access starting in IDLE; dly = ISSUE cycles before m_ready (>= TMO never)
    task automatic access(input logic [3:0] req, input int dly, input logic drop);
        int w;
        logic [31:0] rd;
        logic to;
        w = pick(req);
        core_valid = req;
        @(posedge clk); #1;
        gap = cyc - gcyc;
        gcyc = cyc;
        chk("grant_id", 128'(grant_id), 128'(w));
        chk("m_valid_issue", 128'(m_valid), 128'(1));
        chk("m_addr", 128'(m_addr), 128'(addr[w]));
        chk("m_wdata", 128'(m_wdata), 128'(wd[w]));
        chk("m_wstrb", 128'(m_wstrb), 128'(ws[w]));
        chk("busy_issue", 128'(busy), 128'(1));
        if (drop) core_valid[w] = 1'b0;
        rd = $urandom;
        for (int c = 0; c < TMO; c++) begin
            m_ready = (c == dly);
            m_rdata = m_ready ? rd : $urandom;
            @(posedge clk); #1;
            if (c == dly || c == TMO - 1) break;
            chk("core_ready_wait", 128'(core_ready), 128'(0));
            chk("m_valid_hold", 128'(m_valid), 128'(1));
        end
        m_ready = 1'b0;
        to = dly >= TMO;
        mrd[w] = to ? 32'h0 : rd;
        if (to) terr = 1'b1;
        chk("core_ready_pulse", 128'(core_ready), 128'(1) << w);
        chk("core_rdata", core_rdata, model_rdata());
        chk("timeout_err", 128'(timeout_err), 128'(terr));
        chk("m_valid_resp", 128'(m_valid), 128'(0));
        chk("busy_resp", 128'(busy), 128'(1));
        core_valid = '0;
        @(posedge clk); #1;
        chk("core_ready_clear", 128'(core_ready), 128'(0));
        chk("busy_idle", 128'(busy), 128'(0));
        last_g = w;
    endtask

    initial begin
        model_reset();
        rnd_cores();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_core_rdata", core_rdata, 128'(0));
        chk("rst_grant_id", 128'(grant_id), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;

        // single read by core 2
        rnd_cores();
        addr[2] = 32'h0000_0010;
        ws[2] = 4'b0000;
        drive_cores();
        access(4'b0100, 0, 1'b0);

        // write by core 0
        rnd_cores();
        addr[0] = 32'h1000_0000;
        wd[0] = 32'h0100_0001;
        ws[0] = 4'b1001;
        drive_cores();
        access(4'b0001, 0, 1'b0);

        // m_ready on the last allowed ISSUE cycle completes normally
        rnd_cores();
        access(4'b1000, TMO - 1, 1'b0);

        // full contention: grants 0,1,2,3,0,1 every 3 cycles
        for (int g = 0; g < 6; g++) begin
            rnd_cores();
            access(4'b1111, 0, 1'b0);
            if (g > 0) chk("contention_gap", 128'(gap), 128'(3));
        end

        // sparse contention with wrap-around
        access(4'b1000, 1, 1'b0);
        access(4'b1010, 0, 1'b0);
        access(4'b1010, 2, 1'b1);

        // timeout, then sticky error through normal accesses
        rnd_cores();
        access(4'b0010, 100, 1'b0);
        access(4'b0101, 0, 1'b0);
        access(4'b0101, 3, 1'b0);

        // m_ready while idle is ignored
        m_ready = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("idle_mready_ready", 128'(core_ready), 128'(0));
        chk("idle_mready_rdata", core_rdata, model_rdata());
        chk("idle_mready_busy", 128'(busy), 128'(0));

        for (int r = 0; r < 40; r++) begin
            rnd_cores();
            access(4'($urandom_range(1, 15)), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of ISSUE
        rnd_cores();
        core_valid = 4'b0110;
        @(posedge clk); #1;
        chk("pre_rst_m_valid", 128'(m_valid), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("async_m_valid", 128'(m_valid), 128'(0));
        chk("async_m_addr", 128'(m_addr), 128'(0));
        chk("async_m_wdata", 128'(m_wdata), 128'(0));
        chk("async_m_wstrb", 128'(m_wstrb), 128'(0));
        chk("async_core_rdata", core_rdata, 128'(0));
        chk("async_grant_id", 128'(grant_id), 128'(0));
        chk("async_timeout_err", 128'(timeout_err), 128'(0));
        chk("async_busy", 128'(busy), 128'(0));
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_ready", 128'(core_ready), 128'(0));
        m_ready = 1'b0;
        core_valid = '0;
        reset = 1'b0;
        model_reset();
        rnd_cores();
        access(4'b1111, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares the single on-chip memory/IO port between the N picorv32 cores of the multi-core SoC. Each core presents a native valid/ready memory request; the arbiter grants one at a time, forwards it to the downstream memory/IO decoder, returns the read data and a one-cycle ready to the granted core, and flags a hung downstream access with a timeout.

## Interface
Parameters:
- N_CORES, 4, number of requesting cores (2..8)
- TIMEOUT, 64, cycles to wait for m_ready before aborting an access (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- core_valid  in  N_CORES  per-core request valid
- core_addr  in  32*N_CORES  per-core byte address; slice k is [32k+31:32k]
- core_wdata  in  32*N_CORES  per-core write data
- core_wstrb  in  4*N_CORES  per-core byte strobes; nonzero means write, zero means read
- core_ready  out  N_CORES  one-cycle completion pulse to the granted core
- core_rdata  out  32*N_CORES  per-core read data, valid when the matching core_ready is high
- m_valid  out  1  downstream request valid
- m_addr  out  32  downstream address
- m_wdata  out  32  downstream write data
- m_wstrb  out  4  downstream strobes
- m_ready  in  1  downstream completion, one-cycle pulse
- m_rdata  in  32  downstream read data, valid with m_ready
- grant_id  out  $clog2(N_CORES)  index of the current or last granted core
- busy  out  1  high in ISSUE or RESP
- timeout_err  out  1  sticky: set by any timeout, cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any core_valid, pick the winner = first set bit scanning upward from (last_grant+1) mod N_CORES, wrapping; latch the winner's addr/wdata/wstrb into m_* registers, set grant_id, go to ISSUE. No request: stay.
- ISSUE: m_valid=1, m_* stable. On m_ready: latch m_rdata into the winner's core_rdata slice, go to RESP. On timeout counter reaching TIMEOUT-1 without m_ready: load core_rdata slice with 32'h0000_0000, set timeout_err, go to RESP.
- RESP: core_ready[grant_id]=1 for exactly this cycle, last_grant<=grant_id, return to IDLE. No new grant is made in RESP.
- Only the granted core's core_rdata slice changes; other slices hold.
- Requests from non-granted cores are not acknowledged and must be held by the core; the arbiter does not latch them.
- A core dropping core_valid while granted does not abort the access; the access completes normally.
- m_ready outside ISSUE is ignored.
- Reset (asynchronous, any state): state=IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, core_ready=0, core_rdata=0, grant_id=0, last_grant=N_CORES-1 (so core 0 wins first), timeout counter=0, timeout_err=0, busy=0. Reset mid-ISSUE drops the access without a ready pulse.

## Timing
- All outputs registered except busy (decoded from state).
- Request sampled in IDLE at edge t -> m_valid high from t+1.
- m_ready sampled at edge u -> core_ready high for cycle u+1 -> IDLE at u+2. Earliest next m_valid at u+3.
- Minimum per-access latency (m_ready on first ISSUE cycle): 3 cycles from core_valid to core_ready.
- Timeout counter resets on entering ISSUE, increments each ISSUE cycle; abort at the TIMEOUT-th ISSUE cycle. m_ready arriving on that same cycle wins (normal completion, no error).
- Fairness: with all cores requesting continuously, grants follow 0,1,2,…,N_CORES-1,0,…; no core waits more than N_CORES-1 other accesses.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, ISSUE, RESP), function computing grant-index width from N_CORES, constant for the 32'h0 timeout read value.
- One sub-module: rr_pick, combinational round-robin picker (inputs request vector and last_grant; outputs winner index and any_req).
- Top holds the FSM, the timeout counter, the m_* and core_rdata registers.

## Test plan
- Single read: core 2 reads 0x0000_0010, m_ready after 1 cycle with m_rdata=0xDEAD_BEEF -> m_addr=0x10, m_wstrb=0; core_ready=4'b0100 for one cycle; core_rdata slice 2 = 0xDEADBEEF; other slices unchanged.
- Full contention: all 4 cores hold core_valid, m_ready every first ISSUE cycle -> grant_id sequence 0,1,2,3,0,1; one access every 3 cycles.
- Sparse contention: after a grant to core 3, cores 1 and 3 request -> core 1 wins (wrap-around), core 3 on the next grant.
- Write: core 0 writes 0x1000_0000, wdata 0x0100_0001, wstrb 4'b1001 -> m_* match exactly; core_ready[0] pulses; core_rdata slice 0 = m_rdata as sampled.
- Timeout: TIMEOUT=8, m_ready never asserted -> core_ready pulses after 8 ISSUE cycles, core_rdata slice = 0, timeout_err stays 1 through later normal accesses; m_ready on the 8th ISSUE cycle -> normal completion, timeout_err stays 0.
- Reset mid-ISSUE: assert reset asynchronously during ISSUE -> all outputs 0 immediately, no core_ready pulse; after release, core 0 wins the first grant.
